// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, digit index type and hex-to-segment table for the scan driver
package display_pkg;

    // All segments off (active-low drive).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Digit index shared with the anode decoder.
    typedef logic [1:0] digit_idx_t;

    // Hex value to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] value);
        logic [6:0] s;
        case (value)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - combinational hex digit to active-low seven-segment decoder
//   value : 4-bit hex digit in
//   seg   : 7-bit active-low {g,f,e,d,c,b,a} out
module seg7_hex_decoder
    import display_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    assign seg = hex7(value);

endmodule

// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - 4-digit seven-segment scan controller with double-buffered digits and blanking guard
//   clk, rst     : clock, synchronous active-high reset
//   digits_in    : four hex digits, [3:0] = digit 0 (rightmost)
//   dp_in        : per-digit decimal point request, 1 = lit
//   mask_in      : per-digit enable, 1 = shown
//   load         : one-cycle strobe capturing digits_in/dp_in/mask_in
//   en           : current digit index to the anode decoder
//   seg, dp      : active-low segment and decimal point drive
//   frame_done   : one-cycle pulse after the last slot of each frame
//   Optional: define DISPLAY_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module display_scan_driver
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  mask_in,
    input  logic        load,
    output digit_idx_t  en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int             CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  GUARD    = CW'(GUARD_CYCLES);

    logic [CW-1:0] cnt, cnt_n;
    digit_idx_t    en_n;
    logic          slot_end, frame_wrap;

    logic [15:0]   pend_digits, act_digits, act_digits_n;
    logic [3:0]    pend_dp, pend_mask, act_dp, act_mask, act_dp_n, act_mask_n;
    logic          pend_valid;

    logic [3:0]    cur_digit;
    logic [6:0]    cur_seg, seg_n;
    logic          dp_n, lz_blank;

    seg7_hex_decoder u_dec (
        .value (cur_digit),
        .seg   (cur_seg)
    );

    // Outputs are derived from next-state counter and buffer values so that
    // en, seg and dp all update on the same edge.
    always_comb begin
        slot_end     = (cnt == CNT_LAST);
        frame_wrap   = slot_end && (en == 2'd3);
        cnt_n        = slot_end ? '0 : cnt + 1'b1;
        en_n         = slot_end ? en + 2'd1 : en;

        act_digits_n = act_digits;
        act_dp_n     = act_dp;
        act_mask_n   = act_mask;
        if (frame_wrap) begin
            // A load landing on the wrap edge bypasses the pending buffer.
            if (load) begin
                act_digits_n = digits_in;
                act_dp_n     = dp_in;
                act_mask_n   = mask_in;
            end else if (pend_valid) begin
                act_digits_n = pend_digits;
                act_dp_n     = pend_dp;
                act_mask_n   = pend_mask;
            end
        end

        cur_digit = act_digits_n[{en_n, 2'b00} +: 4];

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        case (en_n)
            2'd1:    lz_blank = (act_digits_n[15:4]  == 12'h000);
            2'd2:    lz_blank = (act_digits_n[15:8]  == 8'h00);
            2'd3:    lz_blank = (act_digits_n[15:12] == 4'h0);
            default: lz_blank = 1'b0;
        endcase
`else
        lz_blank = 1'b0;
`endif

        seg_n = SEG_BLANK;
        dp_n  = 1'b1;
        if (cnt_n >= GUARD && act_mask_n[en_n]) begin
            seg_n = lz_blank ? SEG_BLANK : cur_seg;
            dp_n  = ~act_dp_n[en_n];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            en          <= '0;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_done  <= 1'b0;
            pend_valid  <= 1'b0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_mask   <= '0;
            act_digits  <= '0;
            act_dp      <= '0;
            act_mask    <= '0;
        end else begin
            cnt         <= cnt_n;
            en          <= en_n;
            seg         <= seg_n;
            dp          <= dp_n;
            frame_done  <= frame_wrap;
            act_digits  <= act_digits_n;
            act_dp      <= act_dp_n;
            act_mask    <= act_mask_n;
            if (frame_wrap) begin
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
                pend_mask   <= mask_in;
                pend_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// tb/tb_display_scan_driver.sv - self-checking bench for display_scan_driver
module tb_display_scan_driver;

    localparam int RD    = 8;
    localparam int GC    = 2;
    localparam int FRAME = 4 * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  mask_in = '0;
    logic [1:0]  en;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    display_scan_driver #(.REFRESH_DIV(RD), .GUARD_CYCLES(GC)) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .mask_in    (mask_in),
        .load       (load),
        .en         (en),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: n counts clock edges since reset; one frame spans FRAME edges.
    int          n = 0;
    bit          model_ok = 1'b0;
    logic [15:0] m_dig = '0, p_dig = '0;
    logic [3:0]  m_dp = '0, m_mask = '0, p_dp = '0, p_mask = '0;
    logic        p_flag = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            n <= 0; model_ok <= 1'b1; p_flag <= 1'b0;
            m_dig <= '0; m_dp <= '0; m_mask <= '0;
            p_dig <= '0; p_dp <= '0; p_mask <= '0;
        end else begin
            n <= n + 1;
            if (n % FRAME == FRAME - 1) begin
                if (load) begin
                    m_dig <= digits_in; m_dp <= dp_in; m_mask <= mask_in;
                end else if (p_flag) begin
                    m_dig <= p_dig; m_dp <= p_dp; m_mask <= p_mask;
                end
                p_flag <= 1'b0;
            end else if (load) begin
                p_dig <= digits_in; p_dp <= dp_in; p_mask <= mask_in; p_flag <= 1'b1;
            end
        end
    end

    function automatic logic [6:0] hex_ref(input logic [3:0] v);
        logic [6:0] t [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[v];
    endfunction

    // {en, seg, dp, frame_done} the display must show after n edges.
    function automatic logic [15:0] expected();
        int         e = (n / RD) % 4;
        int         c = n % RD;
        logic [15:0] upper = m_dig >> (4 * e);
        logic [6:0] s = 7'h7F;
        logic       d = 1'b1;
        logic       fd = (n > 0) && (n % FRAME == 0);
        bit         lz = 1'b0;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        lz = (e > 0) && (upper == 16'h0);
`endif
        if (c >= GC && m_mask[e]) begin
            s = lz ? 7'h7F : hex_ref(upper[3:0]);
            d = ~m_dp[e];
        end
        return {5'b0, 2'(e), s, d, fd};
    endfunction

    always @(negedge clk) begin
        if (model_ok)
            check($sformatf("scan n=%0d", n), {5'b0, en, seg, dp, frame_done}, expected());
    end

    task automatic wait_n(input int target);
        int b = 0;
        while (n != target && b < 1000) begin
            @(negedge clk);
            b++;
        end
        if (n != target) begin
            total++;
            $display("FAIL wait_n: reached %0d expected %0d", n, target);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] m);
        digits_in = d; dp_in = p; mask_in = m; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic check_seg(input string name, input logic [6:0] s, input logic d);
        check(name, {8'b0, seg, dp}, {8'b0, s, d});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_n(20);
        check_seg("blank_no_load", 7'h7F, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("reset_state", {5'b0, en, seg, dp, frame_done}, {5'b0, 2'd0, 7'h7F, 1'b1, 1'b0});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_n(10);
        check_seg("blank_after_reset", 7'h7F, 1'b1);

        do_load(16'h1234, 4'h0, 4'hF);
        wait_n(32);
        check("wrap_pulse", {15'b0, frame_done}, 16'h1);
        check_seg("guard_blank", 7'h7F, 1'b1);
        wait_n(33);
        check("pulse_one_cycle", {15'b0, frame_done}, 16'h0);
        wait_n(34);
        check_seg("digit0_4", 7'b0011001, 1'b1);

        wait_n(42);
        do_load(16'hABCD, 4'h0, 4'hF);
        check("pending_set", {15'b0, dut.pend_valid}, 16'h1);
        wait_n(51);
        check_seg("old_frame_2", 7'b0100100, 1'b1);
        wait_n(59);
        check_seg("old_frame_1", 7'b1111001, 1'b1);
        wait_n(67);
        check_seg("new_frame_D", 7'b0100001, 1'b1);
        wait_n(91);
        check_seg("new_frame_A", 7'b0001000, 1'b1);

        wait_n(95);
        do_load(16'h00F0, 4'h0, 4'hF);
        check("pending_clear", {15'b0, dut.pend_valid}, 16'h0);
        wait_n(99);
        check_seg("coinc_digit0", 7'b1000000, 1'b1);
        wait_n(107);
        check_seg("coinc_F", 7'b0001110, 1'b1);

        wait_n(110);
        do_load(16'h8888, 4'b0001, 4'b0101);
        wait_n(131);
        check_seg("mask_en0", 7'b0000000, 1'b0);
        wait_n(139);
        check_seg("mask_en1", 7'h7F, 1'b1);
        wait_n(147);
        check_seg("mask_en2", 7'b0000000, 1'b1);
        wait_n(155);
        check_seg("mask_en3", 7'h7F, 1'b1);

        wait_n(156);
        do_load(16'h0007, 4'h0, 4'hF);
        wait_n(163);
        check_seg("lz_digit0", 7'b1111000, 1'b1);
        wait_n(171);
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        check_seg("lz_digit1", 7'h7F, 1'b1);
`else
        check_seg("lz_digit1", 7'b1000000, 1'b1);
`endif
        wait_n(187);
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        check_seg("lz_digit3", 7'h7F, 1'b1);
`else
        check_seg("lz_digit3", 7'b1000000, 1'b1);
`endif
        wait_n(200);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
